exu_ifetch_rcv: RTL and testbench

EXU_IFETCH_RCV -- requirements
Module: exu_ifetch_rcv

---
 rtl/exu_ifetch_rcv_pkg.sv | 24 ++
 rtl/exu_ifetch_fifo.sv | 58 +++++
 rtl/exu_ifetch_rcv.sv | 130 +++++++++++++
 tb/tb_exu_ifetch_rcv.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/exu_ifetch_rcv_pkg.sv
// ---------------------------------------------------------------------------
// exu_ifetch_rcv_pkg
// Shared MCU definitions for the instruction receive stage: PC and data
// widths, the default instruction buffer depth, the receive FSM state
// encoding, and a helper that classifies an instruction as 32-bit.
// ---------------------------------------------------------------------------
package exu_ifetch_rcv_pkg;

  localparam int PC_SIZE            = 32;
  localparam int XLEN               = 32;
  localparam int FIFO_DEPTH_DEFAULT = 2;

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } exu_rcv_state_e;

  // RISC-V: lower two opcode bits of 2'b11 mark a full 32-bit encoding,
  // anything else is a 16-bit compressed instruction.
  function automatic logic is_rv32(input logic [1:0] ir_lsb);
    return (ir_lsb == 2'b11);
  endfunction

endpackage

// File: rtl/exu_ifetch_fifo.sv
// ---------------------------------------------------------------------------
// exu_ifetch_fifo
// Small synchronous FIFO holding fetched instructions between the IFU and
// decode. Head entry is presented combinationally from the storage array.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   i_push/i_data write one entry (caller guarantees not full)
//   i_pop         remove head entry (caller guarantees not empty)
//   i_flush       discard all entries; has priority over push/pop
//   o_data        head entry
//   o_occupancy   number of entries held
// ---------------------------------------------------------------------------
module exu_ifetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  input  logic             i_flush,
  output logic [WIDTH-1:0] o_data,
  output logic [AW:0]      o_occupancy
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + (AW+1)'(i_push) - (AW+1)'(i_pop);
    end
  end

  // Storage has no reset; validity is tracked solely by r_count.
  always_ff @(posedge clk) begin
    if (i_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_data      = r_mem[r_rd_ptr];
  assign o_occupancy = r_count;

endmodule

// File: rtl/exu_ifetch_rcv.sv
// ---------------------------------------------------------------------------
// exu_ifetch_rcv
// Receives instruction beats from the IFU, buffers them, and presents them
// in order to decode. A taken branch or an exception moves the block into a
// one-cycle FLUSH state that empties the buffer and pulses flush requests
// back to the IFU (with the redirect PC for branches).
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   ifu_i_ifu_valid/ir/pc         incoming instruction beat
//   exu_o_ready                   beat accepted this cycle when valid
//   dec_o_valid/ir/pc/rv32        head instruction toward decode
//   dec_i_ready                   decode consumes head
//   bjp_i_resolve_vld/taken/target branch resolution
//   exu_i_excp                    trap/interrupt flush request
//   exu_o_pipe_flush_req          flush pulse to IFU
//   exu_o_bjp_flush_req/pc        branch redirect pulse and PC
//   exu_o_occupancy               entries held in the buffer
// ---------------------------------------------------------------------------
module exu_ifetch_rcv
  import exu_ifetch_rcv_pkg::*;
#(
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEFAULT,
  localparam int OW        = $clog2(FIFO_DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ifu_i_ifu_valid,
  input  logic [XLEN-1:0]    ifu_i_ir,
  input  logic [PC_SIZE-1:0] ifu_i_pc,
  output logic               exu_o_ready,
  output logic               dec_o_valid,
  output logic [XLEN-1:0]    dec_o_ir,
  output logic [PC_SIZE-1:0] dec_o_pc,
  output logic               dec_o_rv32,
  input  logic               dec_i_ready,
  input  logic               bjp_i_resolve_vld,
  input  logic               bjp_i_taken,
  input  logic [PC_SIZE-1:0] bjp_i_target,
  input  logic               exu_i_excp,
  output logic               exu_o_pipe_flush_req,
  output logic               exu_o_bjp_flush_req,
  output logic [PC_SIZE-1:0] exu_o_bjp_flush_pc,
  output logic [OW-1:0]      exu_o_occupancy
);

  localparam logic [OW-1:0] DEPTH_L = OW'(FIFO_DEPTH);

  exu_rcv_state_e r_state;
  exu_rcv_state_e w_state_next;
  logic           r_bjp_cause;
  logic [PC_SIZE-1:0] r_flush_pc;
  logic           r_rdy_en;      // holds ready low for the first cycle out of reset

  logic                    w_trigger;
  logic                    w_bjp_cause;
  logic                    w_push;
  logic                    w_pop;
  logic                    w_fifo_flush;
  logic [OW-1:0]           w_occ;
  logic [PC_SIZE+XLEN-1:0] w_head;

  // Flush causes are only honoured in RUN; exception overrides a branch.
  assign w_trigger   = (r_state == ST_RUN) &
                       ((bjp_i_resolve_vld & bjp_i_taken) | exu_i_excp);
  assign w_bjp_cause = bjp_i_resolve_vld & bjp_i_taken & ~exu_i_excp;

  always_comb begin
    w_state_next         = r_state;
    exu_o_ready          = 1'b0;
    dec_o_valid          = 1'b0;
    exu_o_pipe_flush_req = 1'b0;
    exu_o_bjp_flush_req  = 1'b0;
    w_fifo_flush         = 1'b0;
    case (r_state)
      ST_RUN: begin
        exu_o_ready = r_rdy_en & (w_occ < DEPTH_L);
        dec_o_valid = (w_occ != '0);
        if (w_trigger) w_state_next = ST_FLUSH;
      end
      ST_FLUSH: begin
        exu_o_pipe_flush_req = 1'b1;
        exu_o_bjp_flush_req  = r_bjp_cause;
        w_fifo_flush         = 1'b1;
        w_state_next         = ST_RUN;
      end
      default: w_state_next = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_RUN;
      r_bjp_cause <= 1'b0;
      r_flush_pc  <= '0;
      r_rdy_en    <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_rdy_en <= 1'b1;
      if (w_trigger) begin
        r_bjp_cause <= w_bjp_cause;
        if (w_bjp_cause) r_flush_pc <= bjp_i_target;
      end
    end
  end

  // A beat arriving in the triggering cycle belongs to the squashed path.
  assign w_push = ifu_i_ifu_valid & exu_o_ready & ~w_trigger;
  assign w_pop  = dec_o_valid & dec_i_ready;

  exu_ifetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (PC_SIZE + XLEN)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_push),
    .i_data      ({ifu_i_pc, ifu_i_ir}),
    .i_pop       (w_pop),
    .i_flush     (w_fifo_flush),
    .o_data      (w_head),
    .o_occupancy (w_occ)
  );

  assign dec_o_pc           = w_head[PC_SIZE+XLEN-1:XLEN];
  assign dec_o_ir           = w_head[XLEN-1:0];
  assign dec_o_rv32         = is_rv32(w_head[1:0]);
  assign exu_o_bjp_flush_pc = r_flush_pc;
  assign exu_o_occupancy    = w_occ;

endmodule

// File: tb/tb_exu_ifetch_rcv.sv
// ---------------------------------------------------------------------------
// tb_exu_ifetch_rcv
// Scoreboard bench: accepted beats are queued and compared against the
// decode side as they pop; handshake and flush outputs are checked every
// cycle against a small reference of the receive behaviour.
// ---------------------------------------------------------------------------
module tb_exu_ifetch_rcv;
  import exu_ifetch_rcv_pkg::*;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               ifu_i_ifu_valid = 1'b0;
  logic [XLEN-1:0]    ifu_i_ir = '0;
  logic [PC_SIZE-1:0] ifu_i_pc = '0;
  logic               exu_o_ready;
  logic               dec_o_valid;
  logic [XLEN-1:0]    dec_o_ir;
  logic [PC_SIZE-1:0] dec_o_pc;
  logic               dec_o_rv32;
  logic               dec_i_ready = 1'b0;
  logic               bjp_i_resolve_vld = 1'b0;
  logic               bjp_i_taken = 1'b0;
  logic [PC_SIZE-1:0] bjp_i_target = '0;
  logic               exu_i_excp = 1'b0;
  logic               exu_o_pipe_flush_req;
  logic               exu_o_bjp_flush_req;
  logic [PC_SIZE-1:0] exu_o_bjp_flush_pc;
  logic [1:0]         exu_o_occupancy;

  exu_ifetch_rcv #(.FIFO_DEPTH(2)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .ifu_i_ifu_valid      (ifu_i_ifu_valid),
    .ifu_i_ir             (ifu_i_ir),
    .ifu_i_pc             (ifu_i_pc),
    .exu_o_ready          (exu_o_ready),
    .dec_o_valid          (dec_o_valid),
    .dec_o_ir             (dec_o_ir),
    .dec_o_pc             (dec_o_pc),
    .dec_o_rv32           (dec_o_rv32),
    .dec_i_ready          (dec_i_ready),
    .bjp_i_resolve_vld    (bjp_i_resolve_vld),
    .bjp_i_taken          (bjp_i_taken),
    .bjp_i_target         (bjp_i_target),
    .exu_i_excp           (exu_i_excp),
    .exu_o_pipe_flush_req (exu_o_pipe_flush_req),
    .exu_o_bjp_flush_req  (exu_o_bjp_flush_req),
    .exu_o_bjp_flush_pc   (exu_o_bjp_flush_pc),
    .exu_o_occupancy      (exu_o_occupancy)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Scoreboard entries are {pc, ir}.
  logic [63:0] sb_q[$];
  logic [63:0] ent;
  bit          exp_flush = 1'b0;
  bit          exp_bjp   = 1'b0;
  bit          exp_en    = 1'b0;
  logic [31:0] exp_pc    = '0;
  int          sz;
  bit          e_ready, e_valid, trig;

  // Sampled on the falling edge; inputs are stable here until the next rise.
  always @(negedge clk) begin
    if (rst) begin
      check("rst_ready", exu_o_ready, 0);
      check("rst_dec_valid", dec_o_valid, 0);
      check("rst_occ", exu_o_occupancy, 0);
      check("rst_pipe_flush", exu_o_pipe_flush_req, 0);
      check("rst_bjp_flush", exu_o_bjp_flush_req, 0);
      check("rst_flush_pc", exu_o_bjp_flush_pc, 0);
      sb_q.delete();
      exp_flush = 1'b0;
      exp_bjp   = 1'b0;
      exp_en    = 1'b0;
      exp_pc    = '0;
    end else begin
      sz      = sb_q.size();
      e_ready = exp_en && !exp_flush && (sz < 2);
      e_valid = !exp_flush && (sz > 0);
      check("ready", exu_o_ready, e_ready);
      check("dec_valid", dec_o_valid, e_valid);
      check("occupancy", exu_o_occupancy, sz);
      check("pipe_flush", exu_o_pipe_flush_req, exp_flush);
      check("bjp_flush", exu_o_bjp_flush_req, exp_flush && exp_bjp);
      check("flush_pc", exu_o_bjp_flush_pc, exp_pc);
      if (e_valid && dec_i_ready) begin
        ent = sb_q.pop_front();
        check("dec_pc", dec_o_pc, ent[63:32]);
        check("dec_ir", dec_o_ir, ent[31:0]);
        check("dec_rv32", dec_o_rv32, (ent[1:0] == 2'b11));
      end
      trig = !exp_flush && ((bjp_i_resolve_vld && bjp_i_taken) || exu_i_excp);
      if (ifu_i_ifu_valid && e_ready && !trig) sb_q.push_back({ifu_i_pc, ifu_i_ir});
      if (exp_flush) sb_q.delete();
      if (trig) begin
        exp_bjp = !exu_i_excp;
        if (!exu_i_excp) exp_pc = bjp_i_target;
      end
      exp_flush = trig;
      exp_en    = 1'b1;
    end
  end

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ir,
                       input logic dr, input logic rv, input logic tk,
                       input logic [31:0] tg, input logic ex);
    ifu_i_ifu_valid   = v;
    ifu_i_pc          = pc;
    ifu_i_ir          = ir;
    dec_i_ready       = dr;
    bjp_i_resolve_vld = rv;
    bjp_i_taken       = tk;
    bjp_i_target      = tg;
    exu_i_excp        = ex;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic dr);
    for (int i = 0; i < n; i++) drive(0, 0, 0, dr, 0, 0, 0, 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    idle(2, 1);

    // In-order streaming with decode always ready
    for (int i = 0; i < 4; i++) drive(1, 32'(i * 4), 32'h13 | 32'(i << 7), 1, 0, 0, 0, 0);
    idle(2, 1);

    // Decode stalled: buffer fills to two, then drains
    for (int i = 0; i < 4; i++) drive(1, 32'(i * 4), 32'h4501 + 32'(i << 8), 0, 0, 0, 0, 0);
    idle(3, 1);

    // Taken branch with two buffered
    drive(1, 32'h40, 32'h00100093, 0, 0, 0, 0, 0);
    drive(1, 32'h44, 32'h00200113, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 1, 32'h100, 0);
    idle(2, 0);

    // Not-taken resolve has no effect
    drive(1, 32'h48, 32'h00300193, 1, 1, 0, 32'h300, 0);
    idle(2, 1);

    // Branch and exception together, with a beat offered that cycle
    drive(1, 32'h80, 32'h00400213, 0, 1, 1, 32'h200, 1);
    idle(2, 1);

    // Resolve/excp during FLUSH are ignored
    drive(0, 0, 0, 1, 1, 1, 32'h180, 0);
    drive(1, 32'h90, 32'h13, 1, 1, 1, 32'h1C0, 1);
    idle(2, 1);

    // 32-bit vs compressed classification
    drive(1, 32'h10, 32'h00000013, 1, 0, 0, 0, 0);
    drive(1, 32'h14, 32'h00004501, 1, 0, 0, 0, 0);
    idle(2, 1);

    // Random traffic with occasional redirects
    for (int i = 0; i < 80; i++)
      drive(1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFE, $urandom,
            1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0),
            1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFE,
            ($urandom_range(0, 19) == 0));
    idle(3, 1);

    // Reset mid-operation with two buffered
    drive(1, 32'h20, 32'h13, 0, 0, 0, 0, 0);
    drive(1, 32'h24, 32'h4501, 0, 0, 0, 0, 0);
    rst = 1'b1;
    idle(2, 0);
    rst = 1'b0;
    idle(3, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
